// File: rtl/i2s_pkg.sv
// i2s_pkg: frame constants and the stereo sample type, shared by the I2S transmitter and the mic-side receiver.
package i2s_pkg;
  localparam int SLOT_BITS     = 32;
  localparam int FRAME_BITS    = 64;
  localparam int LR_HIGH_FIRST = 31;
  localparam int LR_LOW_FIRST  = 63;
  typedef struct packed {
    logic [SLOT_BITS-1:0] left;
    logic [SLOT_BITS-1:0] right;
  } stereo_sample_t;
endpackage

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: BCLK/LRCLK master timing. fall_out marks the cycle BCLK drops; bit_nxt_out is the bit that starts there.
module i2s_clk_gen import i2s_pkg::*; #(
  parameter int BCLK_HALF_PERIOD = 16
) (
  input  logic       clk_in,
  input  logic       rst_in,
  output logic       bclk_out,
  output logic       lrclk_out,
  output logic       fall_out,
  output logic [5:0] bit_nxt_out
);
  localparam int HW = $clog2(BCLK_HALF_PERIOD);
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [5:0] bit_cnt_q, bit_cnt_d;
  logic bclk_q, bclk_d, lrclk_q, lrclk_d, tc;
  always_comb begin
    tc = hcnt_q == HW'(BCLK_HALF_PERIOD - 1);
    hcnt_d = tc ? '0 : hcnt_q + 1'b1;
    bclk_d = tc ? ~bclk_q : bclk_q;
    fall_out = tc && bclk_q;
    bit_nxt_out = (bit_cnt_q == 6'(FRAME_BITS - 1)) ? '0 : bit_cnt_q + 1'b1;
    bit_cnt_d = fall_out ? bit_nxt_out : bit_cnt_q;
    // LRCLK leads the slot by one bit: high for bits 31..62
    lrclk_d = fall_out ? (bit_nxt_out >= 6'(LR_HIGH_FIRST) && bit_nxt_out != 6'(LR_LOW_FIRST)) : lrclk_q;
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hcnt_q <= '0;
      bit_cnt_q <= 6'(LR_LOW_FIRST);
      bclk_q <= 1'b0;
      lrclk_q <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      bit_cnt_q <= bit_cnt_d;
      bclk_q <= bclk_d;
      lrclk_q <= lrclk_d;
    end
  end
  assign bclk_out = bclk_q;
  assign lrclk_out = lrclk_q;
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: I2S master transmitter with a one-entry holding register; replays the last frame on underrun.
// Define I2S_TX_UNDERRUN_CNT_EN to add the saturating underrun_count_out port.
module i2s_tx import i2s_pkg::*; #(
  parameter int BCLK_HALF_PERIOD = 16,
  parameter int SAMPLE_WIDTH     = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [SAMPLE_WIDTH-1:0] left_in,
  input  logic [SAMPLE_WIDTH-1:0] right_in,
  input  logic                    sample_valid_in,
  output logic                    sample_ready_out,
  output logic                    bclk_out,
  output logic                    lrclk_out,
  output logic                    sdata_out,
  output logic                    frame_start_out,
  output logic                    underrun_out
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]             underrun_count_out
`endif
);
  logic fall, accept, load;
  logic [5:0] bit_nxt;
  stereo_sample_t hold_q, hold_d, shift_q, shift_d;
  logic ready_q, ready_d, sdata_q, sdata_d, fs_q, fs_d, ur_q, ur_d;
  i2s_clk_gen #(.BCLK_HALF_PERIOD(BCLK_HALF_PERIOD)) u_clk_gen (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .bclk_out    (bclk_out),
    .lrclk_out   (lrclk_out),
    .fall_out    (fall),
    .bit_nxt_out (bit_nxt)
  );
  function automatic logic slot_bit(input stereo_sample_t s, input logic [5:0] b);
    logic [SLOT_BITS-1:0] w;
    logic [4:0] idx;
    w = b[5] ? s.right : s.left;
    idx = 5'(SAMPLE_WIDTH - 1) - b[4:0];
    return ({1'b0, b[4:0]} < 6'(SAMPLE_WIDTH)) && w[idx];
  endfunction
  always_comb begin
    accept = sample_valid_in && ready_q;
    load = fall && bit_nxt == 6'(LR_LOW_FIRST);
    hold_d = accept ? stereo_sample_t'{left: SLOT_BITS'(left_in), right: SLOT_BITS'(right_in)} : hold_q;
    shift_d = (load && !ready_q) ? hold_q : shift_q;
    ready_d = (load && !ready_q) ? 1'b1 : (accept ? 1'b0 : ready_q);
    // bit 63 still belongs to the outgoing frame, so index the shifter before it reloads
    sdata_d = fall ? slot_bit(shift_q, bit_nxt) : sdata_q;
    fs_d = load;
    ur_d = load && ready_q;
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hold_q <= '0;
      shift_q <= '0;
      ready_q <= 1'b1;
      sdata_q <= 1'b0;
      fs_q <= 1'b0;
      ur_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      shift_q <= shift_d;
      ready_q <= ready_d;
      sdata_q <= sdata_d;
      fs_q <= fs_d;
      ur_q <= ur_d;
    end
  end
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) ucnt_q <= '0;
    else if (ur_d && ucnt_q != 16'hFFFF) ucnt_q <= ucnt_q + 1'b1;
  end
  assign underrun_count_out = ucnt_q;
`endif
  assign sample_ready_out = ready_q;
  assign sdata_out = sdata_q;
  assign frame_start_out = fs_q;
  assign underrun_out = ur_q;
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed bench for i2s_tx with a BCLK-rising-edge deserializer and frame/underrun pulse counters.
module tb_i2s_tx;
  logic clk_in = 0, rst_in = 0, sample_valid_in = 0;
  logic [15:0] left_in = 0, right_in = 0;
  logic sample_ready_out, bclk_out, lrclk_out, sdata_out, frame_start_out, underrun_out;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_count_out;
`endif
  int n_chk = 0, n_fail = 0, cyc = 0, fs_total = 0, ur_total = 0, last_fs = 0;
  bit fs_seen = 0, bprev = 0, lr_prev = 0, have_l = 0;
  logic [31:0] sr = 0;
  logic [15:0] lw = 0;
  logic [31:0] rx_q[$];

  always #5 clk_in = ~clk_in;

  i2s_tx dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .left_in          (left_in),
    .right_in         (right_in),
    .sample_valid_in  (sample_valid_in),
    .sample_ready_out (sample_ready_out),
    .bclk_out         (bclk_out),
    .lrclk_out        (lrclk_out),
    .sdata_out        (sdata_out),
    .frame_start_out  (frame_start_out),
    .underrun_out     (underrun_out)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    .underrun_count_out (underrun_count_out)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bp_pair(input int i);
    logic [15:0] l;
    l = 16'(16'h1111 * (i + 1));
    return {l, l ^ 16'h5A5A};
  endfunction

  // DAC-side view: sample sdata on BCLK rising, close a word when LRCLK changes
  always @(negedge clk_in) begin
    if (!rst_in) begin
      bprev = 0; lr_prev = 0; sr = '0; have_l = 0; fs_seen = 0;
    end else begin
      cyc++;
      if (bclk_out && !bprev) begin
        sr = {sr[30:0], sdata_out};
        if (lrclk_out != lr_prev) begin
          check("slot_trail_zero", {16'h0, sr[15:0]}, 32'h0);
          if (lrclk_out) begin
            lw = sr[31:16]; have_l = 1;
          end else if (have_l) begin
            rx_q.push_back({lw, sr[31:16]}); have_l = 0;
          end
        end
        lr_prev = lrclk_out;
      end
      bprev = bclk_out;
      if (frame_start_out) begin
        fs_total++;
        check("ready_at_fs", {31'h0, sample_ready_out}, 32'h1);
        if (fs_seen) check("frame_period", cyc - last_fs, 2048);
        fs_seen = 1; last_fs = cyc;
      end
      if (underrun_out) ur_total++;
    end
  end

  task automatic wait_fall(input int n);
    for (int k = 0; k < n; k++) begin
      int t = 0;
      bit pb = bclk_out;
      bit got = 0;
      while (!got && t < 100) begin
        @(posedge clk_in); #1; t++;
        got = pb && !bclk_out;
        pb = bclk_out;
      end
      if (!got) check("fall_wait", {31'h0, got}, 32'h1);
    end
  endtask

  task automatic wait_rx(input int n);
    int t = 0;
    while (rx_q.size() < n && t < 40000) begin @(posedge clk_in); #1; t++; end
    check("rx_wait", {31'h0, rx_q.size() >= n}, 32'h1);
  endtask

  task automatic push(input logic [31:0] p);
    int t = 0;
    {left_in, right_in} = p;
    sample_valid_in = 1;
    while (!sample_ready_out && t < 5000) begin @(posedge clk_in); #1; t++; end
    check("push_ready", {31'h0, sample_ready_out}, 32'h1);
    @(posedge clk_in); #1;
    check("ready_drop", {31'h0, sample_ready_out}, 32'h0);
  endtask

  initial begin
    int first, lr_hi;
    bit pb;
    repeat (4) @(posedge clk_in);
    #1;
    check("rst_bclk", {31'h0, bclk_out}, 0);
    check("rst_lrclk", {31'h0, lrclk_out}, 0);
    check("rst_sdata", {31'h0, sdata_out}, 0);
    check("rst_ready", {31'h0, sample_ready_out}, 1);
    check("rst_fs", {31'h0, frame_start_out}, 0);
    check("rst_ur", {31'h0, underrun_out}, 0);
    rst_in = 1;
    first = -1;
    pb = bclk_out;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_in); #1;
      if (pb && !bclk_out) begin first = i; break; end
      pb = bclk_out;
    end
    check("first_fall_clk", first, 31);
    check("bit0_lrclk", {31'h0, lrclk_out}, 0);
    check("bit0_sdata", {31'h0, sdata_out}, 0);
    lr_hi = 0;
    for (int b = 1; b <= 30; b++) begin wait_fall(1); lr_hi += int'(lrclk_out); end
    check("lrclk_low_1_30", lr_hi, 0);
    wait_fall(1);
    check("lrclk_high_31", {31'h0, lrclk_out}, 1);
    check("fs_none_first", fs_total, 0);

    push(32'hA5C30F0F);
    sample_valid_in = 0;
    wait_rx(2);
    check("rx_reset_frame", rx_q[0], 32'h0);
    check("rx_single", rx_q[1], 32'hA5C30F0F);
    check("fs_total_single", fs_total, 2);
    check("ur_total_single", ur_total, 1);

    rx_q.delete();
    for (int i = 0; i < 8; i++) push(bp_pair(i));
    sample_valid_in = 0;
    wait_rx(9);
    check("rx_replay", rx_q[0], 32'hA5C30F0F);
    for (int i = 0; i < 8; i++) check("rx_backpressure", rx_q[i+1], bp_pair(i));
    check("fs_total_bp", fs_total, 11);
    check("ur_total_bp", ur_total, 2);

    rx_q.delete();
    push(32'h80007FFF);
    sample_valid_in = 0;
    wait_rx(4);
    check("rx_last_bp", rx_q[0], bp_pair(7));
    for (int i = 1; i < 4; i++) check("rx_underrun_replay", rx_q[i], 32'h80007FFF);
    check("fs_total_ur", fs_total, 15);
    check("ur_total_ur", ur_total, 5);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("ur_count_ur", {16'h0, underrun_count_out}, 5);
`endif

    rx_q.delete();
    push(32'h12345678);
    sample_valid_in = 0;
    wait_fall(41);
    repeat (20) @(posedge clk_in);
    #1;
    check("pre_rst_full", {31'h0, sample_ready_out}, 0);
    check("pre_rst_bclk", {31'h0, bclk_out}, 1);
    check("pre_rst_lrclk", {31'h0, lrclk_out}, 1);
    check("pre_rst_sdata", {31'h0, sdata_out}, 1);
    #2 rst_in = 0;
    #1;
    check("async_bclk", {31'h0, bclk_out}, 0);
    check("async_lrclk", {31'h0, lrclk_out}, 0);
    check("async_sdata", {31'h0, sdata_out}, 0);
    check("async_ready", {31'h0, sample_ready_out}, 1);
    check("async_fs", {31'h0, frame_start_out}, 0);
    check("async_ur", {31'h0, underrun_out}, 0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("async_ur_count", {16'h0, underrun_count_out}, 0);
`endif
    repeat (3) @(posedge clk_in);
    #1;
    rx_q.delete();
    rst_in = 1;
    wait_rx(2);
    check("rx_after_rst_0", rx_q[0], 32'h0);
    check("rx_after_rst_1", rx_q[1], 32'h0);
    check("fs_total_rst", fs_total, 17);
    check("ur_total_rst", ur_total, 7);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("ur_count_rst", {16'h0, underrun_count_out}, 2);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
